lcd_phrase_sender: RTL

Parametrised 4-bit HD44780-style LCD write sequencer for the Spartan-3E character-LCD path. Accepts a packed string of 1..MAX_CHARS bytes plus a register-select flag, and emits each byte as two nibbles (high first). Each nibble gets its own enable pulse with programmable setup, pulse-width, hold, inter-nibble and inter-byte delays. Sits between the LCD init/command controller and the SF_D/LCD_E/LCD_RS/LCD_RW pins. Replaces the single-byte, fixed-timing writer with a length-driven multi-byte engine that has a busy/done handshake.

---
 rtl/lcd_phrase_sender.sv | 135 +++++++++++++
 1 files changed

// File: rtl/lcd_phrase_sender.sv
// 4-bit HD44780-style LCD write sequencer: sends 1..MAX_CHARS bytes as
// high/low nibble pairs, each with its own timed enable pulse.
module lcd_phrase_sender #(
  parameter int unsigned MAX_CHARS      = 16,
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned E_CYC          = 12,
  parameter int unsigned HOLD_CYC       = 1,
  parameter int unsigned NIBBLE_GAP_CYC = 50,
  parameter int unsigned BYTE_GAP_CYC   = 2000
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             iStart,
  input  logic                             iRS,
  input  logic [$clog2(MAX_CHARS+1)-1:0]   iLength,
  input  logic [8*MAX_CHARS-1:0]           iData,
  output logic                             oBusy,
  output logic                             oDone,
  output logic [3:0]                       oLCD_D,
  output logic                             oLCD_E,
  output logic                             oLCD_RS,
  output logic                             oLCD_RW
);

  localparam int unsigned LW = $clog2(MAX_CHARS + 1);
  localparam int unsigned IW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam int unsigned M1 = (SETUP_CYC > E_CYC) ? SETUP_CYC : E_CYC;
  localparam int unsigned M2 = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
  localparam int unsigned M3 = (M2 > NIBBLE_GAP_CYC) ? M2 : NIBBLE_GAP_CYC;
  localparam int unsigned MAXDLY = (M3 > BYTE_GAP_CYC) ? M3 : BYTE_GAP_CYC;
  localparam int unsigned CW = $clog2(MAXDLY + 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, NGAP, BGAP, DONE} state_t;

  state_t          state, stateNext;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   limit;
  logic            tick;
  logic            timed;
  logic            accept;
  logic [LW-1:0]   clampLen;
  logic [LW-1:0]   lenReg;
  logic [IW-1:0]   idx;
  logic [LW:0]     idxPlus1;
  logic            lastByte;
  logic            nibLo;
  logic            rsReg;
  logic [7:0]      bytesReg [MAX_CHARS];
  logic [7:0]      curByte;
  logic [3:0]      curNib;

  // Timer limit, start acceptance, length clamp and byte/nibble selection
  always_comb begin
    limit = '0;
    timed = 1'b1;
    case (state)
      SETUP:   limit = CW'(SETUP_CYC - 1);
      PULSE:   limit = CW'(E_CYC - 1);
      HOLD:    limit = CW'(HOLD_CYC - 1);
      NGAP:    limit = CW'(NIBBLE_GAP_CYC - 1);
      BGAP:    limit = CW'(BYTE_GAP_CYC - 1);
      default: timed = 1'b0;
    endcase
    tick     = (cnt == limit);
    accept   = ((state == IDLE) || (state == DONE)) && iStart;
    clampLen = (iLength > LW'(MAX_CHARS)) ? LW'(MAX_CHARS) : iLength;
    idxPlus1 = (LW+1)'(idx) + (LW+1)'(1);
    lastByte = (idxPlus1 >= {1'b0, lenReg});
    curByte  = bytesReg[idx];
    curNib   = nibLo ? curByte[3:0] : curByte[7:4];
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: begin
        if (iStart) stateNext = (clampLen == '0) ? DONE : SETUP;
        else        stateNext = IDLE;
      end
      SETUP:   if (tick) stateNext = PULSE;
      PULSE:   if (tick) stateNext = HOLD;
      HOLD:    if (tick) stateNext = nibLo ? BGAP : NGAP;
      NGAP:    if (tick) stateNext = SETUP;
      BGAP:    if (tick) stateNext = lastByte ? DONE : SETUP;
      default: stateNext = IDLE;
    endcase
  end

  // Cycle counter: restarts at zero on every entry to a timed state
  always_ff @(posedge Clock) begin
    if (Reset || !timed || tick) cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end

  // Transaction registers: latched on accept, index/nibble advance at state ends
  always_ff @(posedge Clock) begin
    if (Reset) begin
      lenReg <= '0;
      idx    <= '0;
      nibLo  <= 1'b0;
      rsReg  <= 1'b0;
      for (int unsigned i = 0; i < MAX_CHARS; i++) bytesReg[i] <= '0;
    end else if (accept) begin
      lenReg <= clampLen;
      idx    <= '0;
      nibLo  <= 1'b0;
      rsReg  <= iRS;
      for (int unsigned i = 0; i < MAX_CHARS; i++) bytesReg[i] <= iData[8*i +: 8];
    end else if (state == HOLD && tick && !nibLo) begin
      nibLo <= 1'b1;
    end else if (state == BGAP && tick && !lastByte) begin
      idx   <= idx + IW'(1);
      nibLo <= 1'b0;
    end
  end

  // Output decode from state
  always_comb begin
    oBusy   = (state == SETUP) || (state == PULSE) || (state == HOLD) ||
              (state == NGAP)  || (state == BGAP);
    oDone   = (state == DONE);
    oLCD_E  = (state == PULSE);
    oLCD_D  = ((state == SETUP) || (state == PULSE) || (state == HOLD)) ? curNib : 4'h0;
    oLCD_RS = oBusy ? rsReg : 1'b0;
    oLCD_RW = 1'b0;
  end

endmodule
